// File: rtl/trace_pkg.sv
// trace_pkg: shared kind encodings, entry sizing and saturating arithmetic for the trace unit
package trace_pkg;
  typedef enum logic [1:0] {
    TR_WB    = 2'd0,
    TR_STORE = 2'd1,
    TR_HALT  = 2'd2
  } tr_kind_e;
  localparam int TR_KIND_W = 2;
  // Entry layout is {kind, addr, data, stamp}, packed MSB first
  function automatic int entry_w(input int xlen, input int cnt_w);
    return TR_KIND_W + 2 * xlen + cnt_w;
  endfunction
  // Adds n to v and clamps at the all-ones value of a w-bit counter (w <= 64)
  function automatic logic [63:0] sat_add(input logic [63:0] v, input logic [63:0] n, input int w);
    logic [63:0] mask;
    logic [63:0] sum;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum = v + n;
    return (sum < v || sum > mask) ? mask : sum;
  endfunction
endpackage

// File: rtl/trace_fifo_mp.sv
// trace_fifo_mp: circular buffer accepting up to three ordered pushes and one pop per cycle
module trace_fifo_mp #(
  parameter int W     = 98,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int OW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    push_v,
  input  logic [W-1:0]  push_d0,
  input  logic [W-1:0]  push_d1,
  input  logic [W-1:0]  push_d2,
  input  logic          pop,
  output logic [2:0]    push_acc,
  output logic [OW-1:0] occ,
  output logic [W-1:0]  head_d
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d, p1, p2;
  logic [OW-1:0] occ_q, occ_d, free, n0, n1;
  logic          pop_ok;
  // Space is judged on start-of-cycle occupancy; pushes fill it in slot order, a pop frees nothing until next cycle
  always_comb begin
    free = OW'(DEPTH) - occ_q;
    push_acc[0] = push_v[0] && free != '0;
    n0 = OW'(push_acc[0]);
    push_acc[1] = push_v[1] && n0 < free;
    n1 = n0 + OW'(push_acc[1]);
    push_acc[2] = push_v[2] && n1 < free;
    p1 = wr_q + PW'(push_acc[0]);
    p2 = p1 + PW'(push_acc[1]);
    wr_d = p2 + PW'(push_acc[2]);
    pop_ok = pop && occ_q != '0;
    rd_d = rd_q + PW'(pop_ok);
    occ_d = occ_q + n1 + OW'(push_acc[2]) - OW'(pop_ok);
  end
  // Pointer and occupancy registers; reset discards every queued entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end
  // Storage writes, each accepted push lands in the next consecutive slot
  always_ff @(posedge clk) begin
    if (push_acc[0]) mem_q[wr_q] <= push_d0;
    if (push_acc[1]) mem_q[p1] <= push_d1;
    if (push_acc[2]) mem_q[p2] <= push_d2;
  end
  assign occ    = occ_q;
  assign head_d = (occ_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: logs store/writeback/halt events with cycle stamps and keeps event counters
module trace_monitor import trace_pkg::*; #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] HALT_INSTR  = 32'h0000006f,
  parameter int          HALT_REPEAT = 2,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             st_we,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_wdata,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wdata,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [1:0]       rd_kind,
  output logic [XLEN-1:0]  rd_addr,
  output logic [XLEN-1:0]  rd_data,
  output logic [CNT_W-1:0] rd_stamp,
  output logic             halted,
  output logic             overflow,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [CNT_W-1:0] st_count,
  output logic [CNT_W-1:0] drop_count
);
  localparam int EW = entry_w(XLEN, CNT_W);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  logic [EW-1:0]            e_st, e_wb, e_halt, head;
  logic [2:0]               ev, acc, drop;
  logic [1:0]               n_drop;
  logic [$clog2(DEPTH):0]   occ;
  logic                     active, hit;
  logic [RW-1:0]            rep_q, rep_d;
  logic [CNT_W-1:0]         cyc_q, cyc_d, wb_q, wb_d, st_q, st_d, drop_q, drop_d;
  logic                     halted_q, ovf_q;
  // Event qualification in STORE, WB, HALT priority order plus saturating counter updates
  always_comb begin
    active = !halted_q;
    hit    = if_instr == HALT_INSTR;
    ev[0]  = active && st_we;
    ev[1]  = active && wb_regwrite && wb_rd != 5'd0;
    ev[2]  = active && hit && rep_q == RW'(HALT_REPEAT - 1);
    rep_d  = !active ? rep_q : hit ? rep_q + 1'b1 : '0;
    e_st   = {TR_STORE, st_addr, st_wdata, cyc_q};
    e_wb   = {TR_WB, XLEN'(wb_rd), wb_wdata, cyc_q};
    e_halt = {TR_HALT, if_pc, XLEN'(if_instr), cyc_q};
    drop   = ev & ~acc;
    n_drop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    cyc_d  = CNT_W'(sat_add(64'(cyc_q), 64'(active), CNT_W));
    wb_d   = CNT_W'(sat_add(64'(wb_q), 64'(ev[1]), CNT_W));
    st_d   = CNT_W'(sat_add(64'(st_q), 64'(ev[0]), CNT_W));
    drop_d = CNT_W'(sat_add(64'(drop_q), 64'(n_drop), CNT_W));
  end
  // Counter, halt and overflow state; halted and overflow stay set until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q    <= '0;
      cyc_q    <= '0;
      wb_q     <= '0;
      st_q     <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      cyc_q    <= cyc_d;
      wb_q     <= wb_d;
      st_q     <= st_d;
      drop_q   <= drop_d;
      halted_q <= halted_q | ev[2];
      ovf_q    <= ovf_q | (|drop);
    end
  end
  trace_fifo_mp #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_v(ev),
    .push_d0(e_st),
    .push_d1(e_wb),
    .push_d2(e_halt),
    .pop(rd_ready),
    .push_acc(acc),
    .occ(occ),
    .head_d(head)
  );
  assign rd_valid = occ != '0;
  assign {rd_kind, rd_addr, rd_data, rd_stamp} = head;
  assign halted     = halted_q;
  assign overflow   = ovf_q;
  assign cyc_count  = cyc_q;
  assign wb_count   = wb_q;
  assign st_count   = st_q;
  assign drop_count = drop_q;
endmodule
